tri_port_rr_scheduler: RTL

- Shares one N-word register memory between three requesters: left (L), middle (M) and right (R).
- Performs at most one access per clock. The winner is picked by rotating (round-robin) priority, so no port can be starved.
- Each port uses a req/ack handshake. Read data is returned on a per-port registered bus.
- Sits between the three port devices and the storage; replaces fixed-priority sharing of that storage.

---
 rtl/tri_port_rr_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tri_port_rr_scheduler.sv
// Three-port register memory with round-robin access arbitration.
// One access per clock; each request is acknowledged by a single-cycle ack pulse.
module tri_port_rr_scheduler #(
    parameter int N             = 4,
    parameter int no_addr_lines = 2,
    parameter int wordsize      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     L_req,
    input  logic                     M_req,
    input  logic                     R_req,
    input  logic [no_addr_lines-1:0] L_port_addr,
    input  logic [no_addr_lines-1:0] M_port_addr,
    input  logic [no_addr_lines-1:0] R_port_addr,
    input  logic                     L_write_enable,
    input  logic                     M_write_enable,
    input  logic                     R_write_enable,
    input  logic [wordsize-1:0]      L_data,
    input  logic [wordsize-1:0]      M_data,
    input  logic [wordsize-1:0]      R_data,
    output logic                     L_ack,
    output logic                     M_ack,
    output logic                     R_ack,
    output logic [wordsize-1:0]      L_data_read,
    output logic [wordsize-1:0]      M_data_read,
    output logic [wordsize-1:0]      R_data_read,
    output logic [1:0]               grant_id
);

    typedef enum logic [1:0] {
        PTR_L = 2'd0,
        PTR_M = 2'd1,
        PTR_R = 2'd2
    } rr_ptr_e;

    rr_ptr_e                  last_q, last_d;
    logic [wordsize-1:0]      mem_q [N];
    logic [wordsize-1:0]      mem_d [N];
    logic [wordsize-1:0]      rd_q  [3];
    logic [wordsize-1:0]      rd_d  [3];
    logic [2:0]               ack_q, ack_d;
    logic [1:0]               gid_q, gid_d;

    logic [2:0]               req_a;
    logic [2:0]               we_a;
    logic [no_addr_lines-1:0] addr_a  [3];
    logic [wordsize-1:0]      wdata_a [3];

    logic [2:0]               elig;
    logic                     grant;
    logic [1:0]               win;
    logic [1:0]               cand;
    logic [no_addr_lines-1:0] sel_addr;
    logic                     in_range;

    assign req_a      = {R_req, M_req, L_req};
    assign we_a       = {R_write_enable, M_write_enable, L_write_enable};
    assign addr_a[0]  = L_port_addr;
    assign addr_a[1]  = M_port_addr;
    assign addr_a[2]  = R_port_addr;
    assign wdata_a[0] = L_data;
    assign wdata_a[1] = M_data;
    assign wdata_a[2] = R_data;

    always_comb begin
        mem_d    = mem_q;
        rd_d     = rd_q;
        ack_d    = '0;
        gid_d    = '0;
        last_d   = last_q;
        grant    = 1'b0;
        win      = '0;
        cand     = '0;
        sel_addr = '0;
        in_range = 1'b0;

        // A port whose ack is still high is masked so one request yields one access.
        elig = req_a & ~ack_q;

        for (int unsigned k = 1; k <= 3; k++) begin
            cand = 2'((32'(last_q) + k) % 32'd3);
            if (!grant && elig[cand]) begin
                grant = 1'b1;
                win   = cand;
            end
        end

        if (grant) begin
            ack_d[win] = 1'b1;
            gid_d      = win + 2'd1;
            last_d     = rr_ptr_e'(win);
            sel_addr   = addr_a[win];
            in_range   = int'(sel_addr) < N;
            if (we_a[win]) begin
                if (in_range) begin
                    mem_d[sel_addr] = wdata_a[win];
                end
            end else begin
                rd_d[win] = in_range ? mem_q[sel_addr] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            rd_q   <= '{default: '0};
            ack_q  <= '0;
            gid_q  <= '0;
            last_q <= PTR_R;
        end else begin
            mem_q  <= mem_d;
            rd_q   <= rd_d;
            ack_q  <= ack_d;
            gid_q  <= gid_d;
            last_q <= last_d;
        end
    end

    assign L_ack       = ack_q[0];
    assign M_ack       = ack_q[1];
    assign R_ack       = ack_q[2];
    assign L_data_read = rd_q[0];
    assign M_data_read = rd_q[1];
    assign R_data_read = rd_q[2];
    assign grant_id    = gid_q;

endmodule
